// File: rtl/nv_nvdla_cacc_pkg.sv
// Shared CACC constants: pd field layout and default atom geometry.
// Used by the CMAC result receiver and its skew FIFOs.
package nv_nvdla_cacc_pkg;

   localparam int PD_WIDTH       = 9;
   localparam int PD_STRIPE_ST   = 0;
   localparam int PD_STRIPE_END  = 1;
   localparam int PD_CHANNEL_END = 2;
   localparam int PD_LAYER_END   = 3;
   localparam int PD_TAG_LSB     = 4;
   localparam int PD_TAG_MSB     = 8;

   localparam int DEF_ATOMK_HALF   = 8;
   localparam int DEF_RESULT_WIDTH = 22;
   localparam int DEF_FIFO_DEPTH   = 4;

   typedef logic [PD_WIDTH-1:0] pd_t;

endpackage

// File: rtl/nv_nvdla_cacc_mac_rx_fifo.sv
// Flop-based synchronous FIFO absorbing skew between CMAC halves.
// A push while full is ignored unless a pop happens in the same cycle.
module nv_nvdla_cacc_mac_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/nv_nvdla_cacc_mac_rx.sv
// CMAC->CACC receiver: pairs half-atom beats into full-atom beats.
// Optional pair consistency check enabled by CACC_MAC_RX_CHECK_EN.
module nv_nvdla_cacc_mac_rx
   import nv_nvdla_cacc_pkg::*;
#(
   parameter int ATOMK_HALF   = DEF_ATOMK_HALF,
   parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic                                nvdla_core_clk,
   input  logic                                nvdla_core_rst,
   input  logic                                mac_a_pvld,
   input  logic [ATOMK_HALF-1:0]               mac_a_mask,
   input  logic                                mac_a_mode,
   input  logic [ATOMK_HALF*RESULT_WIDTH-1:0]  mac_a_data,
   input  logic [PD_WIDTH-1:0]                 mac_a_pd,
   input  logic                                mac_b_pvld,
   input  logic [ATOMK_HALF-1:0]               mac_b_mask,
   input  logic                                mac_b_mode,
   input  logic [ATOMK_HALF*RESULT_WIDTH-1:0]  mac_b_data,
   input  logic [PD_WIDTH-1:0]                 mac_b_pd,
   output logic                                accu_pvld,
   output logic [2*ATOMK_HALF-1:0]             accu_mask,
   output logic                                accu_mode,
   output logic [2*ATOMK_HALF*RESULT_WIDTH-1:0] accu_data,
   output logic [PD_WIDTH-1:0]                 accu_pd,
   output logic                                layer_done,
   output logic [15:0]                         stripe_cnt,
   output logic                                err_overflow,
   output logic                                err_mismatch
);

   localparam int HW = ATOMK_HALF * RESULT_WIDTH;
   localparam int EW = ATOMK_HALF + 1 + PD_WIDTH + HW;

   logic [EW-1:0]         a_rdata, b_rdata;
   logic                  a_full, a_empty, b_full, b_empty;
   logic                  pop;
   logic [ATOMK_HALF-1:0] a_mask_q, b_mask_q;
   logic                  a_mode_q, b_mode_q;
   pd_t                   a_pd_q, b_pd_q;
   logic [HW-1:0]         a_data_q, b_data_q;
   logic [2*HW-1:0]       merged_data;
   logic                  ovf_set;

   assign pop = !a_empty && !b_empty;

   nv_nvdla_cacc_mac_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo_a (
      .clk   (nvdla_core_clk),
      .rst   (nvdla_core_rst),
      .push  (mac_a_pvld),
      .wdata ({mac_a_mask, mac_a_mode, mac_a_pd, mac_a_data}),
      .pop   (pop),
      .rdata (a_rdata),
      .full  (a_full),
      .empty (a_empty)
   );

   nv_nvdla_cacc_mac_rx_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo_b (
      .clk   (nvdla_core_clk),
      .rst   (nvdla_core_rst),
      .push  (mac_b_pvld),
      .wdata ({mac_b_mask, mac_b_mode, mac_b_pd, mac_b_data}),
      .pop   (pop),
      .rdata (b_rdata),
      .full  (b_full),
      .empty (b_empty)
   );

   assign {a_mask_q, a_mode_q, a_pd_q, a_data_q} = a_rdata;
   assign {b_mask_q, b_mode_q, b_pd_q, b_data_q} = b_rdata;

   // A beat is lost only when its FIFO is full and no pair drains it
   assign ovf_set = (mac_a_pvld && a_full && !pop) ||
                    (mac_b_pvld && b_full && !pop);

   always_comb begin
      merged_data = '0;
      for (int k = 0; k < ATOMK_HALF; k++) begin
         if (a_mask_q[k])
            merged_data[k*RESULT_WIDTH +: RESULT_WIDTH] =
               a_data_q[k*RESULT_WIDTH +: RESULT_WIDTH];
         if (b_mask_q[k])
            merged_data[(ATOMK_HALF+k)*RESULT_WIDTH +: RESULT_WIDTH] =
               b_data_q[k*RESULT_WIDTH +: RESULT_WIDTH];
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         accu_pvld  <= 1'b0;
         accu_mask  <= '0;
         accu_mode  <= 1'b0;
         accu_data  <= '0;
         accu_pd    <= '0;
         layer_done <= 1'b0;
      end else begin
         accu_pvld  <= pop;
         layer_done <= pop && a_pd_q[PD_LAYER_END];
         if (pop) begin
            accu_mask <= {b_mask_q, a_mask_q};
            accu_mode <= a_mode_q;
            accu_data <= merged_data;
            accu_pd   <= a_pd_q;
         end
      end
   end

   // Counts stripes of the visible output beat; layer_end wins over stripe_end
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         stripe_cnt <= '0;
      end else if (accu_pvld && accu_pd[PD_LAYER_END]) begin
         stripe_cnt <= '0;
      end else if (accu_pvld && accu_pd[PD_STRIPE_END]) begin
         stripe_cnt <= stripe_cnt + 16'd1;
      end
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) err_overflow <= 1'b0;
      else if (ovf_set)   err_overflow <= 1'b1;
   end

`ifdef CACC_MAC_RX_CHECK_EN
   logic pair_diff;
   logic err_mm_q;

   assign pair_diff = (a_pd_q != b_pd_q) || (a_mode_q != b_mode_q);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst)      err_mm_q <= 1'b0;
      else if (pop && pair_diff) err_mm_q <= 1'b1;
   end

   assign err_mismatch = err_mm_q;
`else
   logic unused_b_side;
   assign unused_b_side = ^{b_pd_q, b_mode_q};
   assign err_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_mac_rx.sv
// Randomized bench for nv_nvdla_cacc_mac_rx against a queue-based model.
// Honours CACC_MAC_RX_CHECK_EN for the expected err_mismatch behaviour.
module tb_nv_nvdla_cacc_mac_rx;
   import nv_nvdla_cacc_pkg::*;

   localparam int AH = 8;
   localparam int RW = 22;
   localparam int FD = 4;
   localparam int HW = AH * RW;

   typedef struct packed {
      logic [AH-1:0] mask;
      logic          mode;
      logic [8:0]    pd;
      logic [HW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_vld = 1'b0;
   logic b_vld = 1'b0;
   beat_t a_in = '0;
   beat_t b_in = '0;

   logic            accu_pvld;
   logic [2*AH-1:0] accu_mask;
   logic            accu_mode;
   logic [2*HW-1:0] accu_data;
   logic [8:0]      accu_pd;
   logic            layer_done;
   logic [15:0]     stripe_cnt;
   logic            err_overflow;
   logic            err_mismatch;

   beat_t qa[$];
   beat_t qb[$];
   logic            e_pvld, e_mode, e_ld, e_ovf, e_mm;
   logic [2*AH-1:0] e_mask;
   logic [2*HW-1:0] e_data;
   logic [8:0]      e_pd;
   logic [15:0]     e_cnt;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nv_nvdla_cacc_mac_rx #(
      .ATOMK_HALF   (AH),
      .RESULT_WIDTH (RW),
      .FIFO_DEPTH   (FD)
   ) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .mac_a_pvld     (a_vld),
      .mac_a_mask     (a_in.mask),
      .mac_a_mode     (a_in.mode),
      .mac_a_data     (a_in.data),
      .mac_a_pd       (a_in.pd),
      .mac_b_pvld     (b_vld),
      .mac_b_mask     (b_in.mask),
      .mac_b_mode     (b_in.mode),
      .mac_b_data     (b_in.data),
      .mac_b_pd       (b_in.pd),
      .accu_pvld      (accu_pvld),
      .accu_mask      (accu_mask),
      .accu_mode      (accu_mode),
      .accu_data      (accu_data),
      .accu_pd        (accu_pd),
      .layer_done     (layer_done),
      .stripe_cnt     (stripe_cnt),
      .err_overflow   (err_overflow),
      .err_mismatch   (err_mismatch)
   );

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t rnd_beat();
      beat_t b;
      b.mask = 8'($urandom);
      b.mode = 1'($urandom);
      b.pd   = 9'($urandom);
      for (int i = 0; i < HW; i++) b.data[i] = 1'($urandom);
      return b;
   endfunction

   function automatic beat_t idx_beat(input logic [AH-1:0] m,
                                      input logic [8:0] pd);
      beat_t b;
      b.mask = m;
      b.mode = 1'b0;
      b.pd   = pd;
      for (int k = 0; k < AH; k++) b.data[k*RW +: RW] = RW'(k);
      return b;
   endfunction

   function automatic logic [2*HW-1:0] merge(input beat_t pa, input beat_t pb);
      logic [2*HW-1:0] d = '0;
      for (int k = 0; k < AH; k++) begin
         if (pa.mask[k]) d[k*RW +: RW]      = pa.data[k*RW +: RW];
         if (pb.mask[k]) d[(AH+k)*RW +: RW] = pb.data[k*RW +: RW];
      end
      return d;
   endfunction

   // Advance one clock: update the model with the present inputs, then compare
   task automatic cycle();
      beat_t pa, pb;
      if (rst) begin
         qa.delete(); qb.delete();
         e_pvld = 0; e_mask = '0; e_mode = 0; e_data = '0; e_pd = '0;
         e_ld = 0; e_cnt = '0; e_ovf = 0; e_mm = 0;
      end else begin
         if (e_pvld && e_pd[PD_LAYER_END]) e_cnt = '0;
         else if (e_pvld && e_pd[PD_STRIPE_END]) e_cnt = e_cnt + 16'd1;
         if (qa.size() > 0 && qb.size() > 0) begin
            pa = qa.pop_front();
            pb = qb.pop_front();
            e_pvld = 1;
            e_mask = {pb.mask, pa.mask};
            e_mode = pa.mode;
            e_pd   = pa.pd;
            e_data = merge(pa, pb);
`ifdef CACC_MAC_RX_CHECK_EN
            if (pa.pd != pb.pd || pa.mode != pb.mode) e_mm = 1;
`endif
         end else begin
            e_pvld = 0;
         end
         e_ld = e_pvld && e_pd[PD_LAYER_END];
         if (a_vld) begin
            if (qa.size() < FD) qa.push_back(a_in);
            else e_ovf = 1;
         end
         if (b_vld) begin
            if (qb.size() < FD) qb.push_back(b_in);
            else e_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("pvld",  512'(accu_pvld),    512'(e_pvld));
      chk("mask",  512'(accu_mask),    512'(e_mask));
      chk("mode",  512'(accu_mode),    512'(e_mode));
      chk("pd",    512'(accu_pd),      512'(e_pd));
      chk("data",  512'(accu_data),    512'(e_data));
      chk("ldone", 512'(layer_done),   512'(e_ld));
      chk("scnt",  512'(stripe_cnt),   512'(e_cnt));
      chk("ovf",   512'(err_overflow), 512'(e_ovf));
      chk("mism",  512'(err_mismatch), 512'(e_mm));
   endtask

   task automatic drive(input logic va, input beat_t ba,
                        input logic vb, input beat_t bb);
      a_vld = va; a_in = ba;
      b_vld = vb; b_in = bb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         a_vld = 0; b_vld = 0;
         cycle();
      end
   endtask

   initial begin
      beat_t ba, bb;
      logic  exp_mm;
      // Reset state
      idle(2);
      rst = 1'b0;
      idle(2);

      // Aligned pair, mask FF/0F, lane data = lane index
      drive(1, idx_beat(8'hFF, 9'h0), 1, idx_beat(8'h0F, 9'h0));
      cycle();
      idle(1);
      chk("t1_pvld", 512'(accu_pvld), 512'(1));
      chk("t1_mask", 512'(accu_mask), 512'(16'h0FFF));
      chk("t1_b_hi", 512'(accu_data[2*HW-1 : (AH+4)*RW]), 512'(0));
      idle(2);

      // a leads b by 3 over a 6-beat burst
      for (int t = 0; t < 9; t++) begin
         drive(t < 6, rnd_beat(), t >= 3, rnd_beat());
         cycle();
      end
      idle(3);
      chk("skew_ovf", 512'(err_overflow), 512'(0));

      // a leads by 5 with b silent: 5th a beat dropped
      for (int t = 0; t < 5; t++) begin
         drive(1, rnd_beat(), 0, rnd_beat());
         cycle();
      end
      chk("ovf_set", 512'(err_overflow), 512'(1));
      for (int t = 0; t < 5; t++) begin
         drive(0, rnd_beat(), 1, rnd_beat());
         cycle();
      end
      idle(3);

      // Reset with beats held in both FIFOs
      for (int t = 0; t < 3; t++) begin
         drive(1, rnd_beat(), t == 2, rnd_beat());
         cycle();
      end
      rst = 1'b1;
      a_vld = 0; b_vld = 0;
      cycle();
      chk("rst_pvld", 512'(accu_pvld), 512'(0));
      chk("rst_data", 512'(accu_data), 512'(0));
      chk("rst_ovf",  512'(err_overflow), 512'(0));
      rst = 1'b0;
      idle(4);

      // Three stripe_end beats then a layer_end beat
      for (int t = 0; t < 4; t++) begin
         ba = idx_beat(8'hFF, (t < 3) ? 9'h002 : 9'h008);
         drive(1, ba, 1, ba);
         cycle();
      end
      idle(1);
      chk("ly_done", 512'(layer_done), 512'(1));
      chk("ly_cnt3", 512'(stripe_cnt), 512'(3));
      idle(1);
      chk("ly_cnt0", 512'(stripe_cnt), 512'(0));
      chk("ly_once", 512'(layer_done), 512'(0));
      idle(1);

      // Tag mismatch: a tag 5, b tag 6
      ba = idx_beat(8'hFF, {5'd5, 4'h0});
      bb = idx_beat(8'hFF, {5'd6, 4'h0});
      drive(1, ba, 1, bb);
      cycle();
      idle(1);
`ifdef CACC_MAC_RX_CHECK_EN
      exp_mm = 1'b1;
`else
      exp_mm = 1'b0;
`endif
      chk("mm_flag", 512'(err_mismatch), 512'(exp_mm));
      chk("mm_tag",  512'(accu_pd[PD_TAG_MSB:PD_TAG_LSB]), 512'(5));
      idle(2);

      // Random traffic, mostly consistent pairs
      for (int t = 0; t < 400; t++) begin
         ba = rnd_beat();
         bb = rnd_beat();
         if ($urandom_range(0, 7) != 0) begin
            bb.pd = ba.pd;
            bb.mode = ba.mode;
         end
         drive($urandom_range(0, 3) != 0, ba, $urandom_range(0, 3) != 0, bb);
         if (t == 200) rst = 1'b1;
         if (t == 202) rst = 1'b0;
         cycle();
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
